// File: rtl/snes_dev_pkg.sv
// Shared constants for the SNES/NES controller device: register map, CTRL bit
// positions, frame lengths and the frame builder that orders buttons on the wire.
package snes_dev_pkg;

  localparam logic [3:0] ADDR_BTN   = 4'h0;
  localparam logic [3:0] ADDR_EXT   = 4'h1;
  localparam logic [3:0] ADDR_CTRL  = 4'h2;
  localparam logic [3:0] ADDR_POLLS = 4'h3;
  localparam logic [3:0] ADDR_TURBO = 4'h4;

  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_BUSY_BIT = 7;

  localparam logic [4:0] NES_FRAME_LEN  = 5'd8;
  localparam logic [4:0] SNES_FRAME_LEN = 5'd16;

  function automatic logic [4:0] frame_len(input logic snes);
    return snes ? SNES_FRAME_LEN : NES_FRAME_LEN;
  endfunction

  // Bit 15 leaves first; a 1 means pressed. Trailing positions are released.
  function automatic logic [15:0] build_frame(input logic snes, input logic [7:0] btn,
                                              input logic [3:0] ext);
    if (snes)
      return {btn[1], ext[2], btn[2], btn[3], btn[4], btn[5], btn[6], btn[7],
              btn[0], ext[3], ext[1], ext[0], 4'b0000};
    else
      return {btn[0], btn[1], btn[2], btn[3], btn[4], btn[5], btn[6], btn[7], 8'h00};
  endfunction

endpackage

// File: rtl/snes_dev_shifter.sv
// Console-facing serial engine: latch/clock edge detectors, 16-bit pressed-flag
// shift register and the saturating bit counter that drives busy.
module snes_dev_shifter
  import snes_dev_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        latch_i,
  input  logic        cclk_i,
  input  logic        mode_i,
  input  logic [15:0] frame_i,
  output logic        serial_o,
  output logic        latch_fall_o,
  output logic        busy_o
);

  logic        latch_prev_q, latch_prev_d;
  logic        cclk_prev_q, cclk_prev_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        frame_mode_q, frame_mode_d;
  logic        active_q, active_d;
  logic        cclk_rise;
  logic [4:0]  len;

  assign latch_fall_o = latch_prev_q & ~latch_i;
  assign cclk_rise    = cclk_i & ~cclk_prev_q;
  assign len          = frame_len(frame_mode_q);

  always_comb begin
    latch_prev_d = latch_i;
    cclk_prev_d  = cclk_i;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    frame_mode_d = frame_mode_q;
    active_d     = active_q;
    if (latch_i) begin
      shift_d      = frame_i;
      cnt_d        = '0;
      frame_mode_d = mode_i;
      active_d     = 1'b0;
    end else begin
      if (latch_fall_o) active_d = 1'b1;
      if (cclk_rise) begin
        if (cnt_q != len) cnt_d = cnt_q + 5'd1;
        // Once the frame is exhausted the wire sits at "pressed", even in NES
        // mode where released padding would otherwise still be queued.
        shift_d = (cnt_d == len) ? '1 : {shift_q[14:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_prev_q <= 1'b0;
      cclk_prev_q  <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      frame_mode_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      latch_prev_q <= latch_prev_d;
      cclk_prev_q  <= cclk_prev_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      frame_mode_q <= frame_mode_d;
      active_q     <= active_d;
    end
  end

  assign serial_o = shift_q[15];
  assign busy_o   = active_q & (cnt_q != len);

endmodule

// File: rtl/tqvp_snes_device.sv
// TinyQV peripheral emulating an NES/SNES controller from CPU button registers.
// Optional turbo register at 0x4 is built when SNES_DEVICE_TURBO_EN is defined.
module tqvp_snes_device
  import snes_dev_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [7:0]  btn_q, btn_d;
  logic [3:0]  ext_q, ext_d;
  logic        mode_q, mode_d;
  logic [7:0]  polls_q, polls_d;
  logic [7:0]  load_btn;
  logic [15:0] frame_load;
  logic        serial, latch_fall, busy;
  logic        unused_ui;
`ifdef SNES_DEVICE_TURBO_EN
  logic [7:0]  turbo_q, turbo_d;
  logic        phase_q, phase_d;
`endif

  always_comb begin
    btn_d  = btn_q;
    ext_d  = ext_q;
    mode_d = mode_q;
`ifdef SNES_DEVICE_TURBO_EN
    turbo_d = turbo_q;
    phase_d = phase_q ^ latch_fall;
`endif
    if (data_write) begin
      case (address)
        ADDR_BTN:   btn_d  = data_in;
        ADDR_EXT:   ext_d  = data_in[3:0];
        ADDR_CTRL:  mode_d = data_in[CTRL_MODE_BIT];
`ifdef SNES_DEVICE_TURBO_EN
        ADDR_TURBO: turbo_d = data_in;
`endif
        default: ;
      endcase
    end
    // A clear from the CPU wins over a coincident poll.
    if (data_write && (address == ADDR_POLLS)) polls_d = '0;
    else if (latch_fall)                       polls_d = polls_q + 8'd1;
    else                                       polls_d = polls_q;
  end

`ifdef SNES_DEVICE_TURBO_EN
  assign load_btn = btn_q & ~(turbo_q & {8{phase_q}});
`else
  assign load_btn = btn_q;
`endif
  assign frame_load = build_frame(mode_q, load_btn, ext_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= '0;
      ext_q   <= '0;
      mode_q  <= 1'b0;
      polls_q <= '0;
`ifdef SNES_DEVICE_TURBO_EN
      turbo_q <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      btn_q   <= btn_d;
      ext_q   <= ext_d;
      mode_q  <= mode_d;
      polls_q <= polls_d;
`ifdef SNES_DEVICE_TURBO_EN
      turbo_q <= turbo_d;
      phase_q <= phase_d;
`endif
    end
  end

  snes_dev_shifter u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .latch_i     (ui_in[5]),
    .cclk_i      (ui_in[6]),
    .mode_i      (mode_q),
    .frame_i     (frame_load),
    .serial_o    (serial),
    .latch_fall_o(latch_fall),
    .busy_o      (busy)
  );

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_BTN:   data_out = btn_q;
      ADDR_EXT:   data_out = {4'b0000, ext_q};
      ADDR_CTRL: begin
        data_out[CTRL_BUSY_BIT] = busy;
        data_out[CTRL_MODE_BIT] = mode_q;
      end
      ADDR_POLLS: data_out = polls_q;
`ifdef SNES_DEVICE_TURBO_EN
      ADDR_TURBO: data_out = turbo_q;
`endif
      default: ;
    endcase
  end

  // The wire is active-low: a pressed flag pulls it low.
  assign uo_out    = {6'b000000, ~serial, 1'b0};
  assign unused_ui = ^{ui_in[7], ui_in[4:0]};

endmodule

// File: tb/tb_tqvp_snes_device.sv
// Self-checking bench for tqvp_snes_device: directed protocol cases plus random
// frames, checked by a queue-based scoreboard against a button-order model.
module tb_tqvp_snes_device;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  tqvp_snes_device dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ui_in     (ui_in),
    .uo_out    (uo_out),
    .address   (address),
    .data_write(data_write),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         sel_q[$];
  string      name_q[$];
  logic       obs_strobe = 1'b0;

  // Reference state: CPU-visible registers and the frame captured at latch.
  logic [7:0] m_btn, m_turbo, m_polls;
  logic [3:0] m_ext;
  logic       m_mode;
  int         m_falls;
  logic       f_snes, f_active;
  logic [7:0] f_btn;
  logic [3:0] f_ext;
  int         f_k;

  // Wire level for the k-th bit after latch fall (0 = first bit out).
  function automatic logic model_wire(input logic snes, input logic [7:0] b,
                                      input logic [3:0] e, input int k);
    logic pressed;
    logic [2:0] i;
    pressed = 1'b1;
    i = k[2:0];
    if (!snes) begin
      if (k < 8) pressed = b[i];
    end else begin
      case (k)
        0: pressed = b[1];
        1: pressed = e[2];
        2, 3, 4, 5, 6, 7: pressed = b[i];
        8: pressed = b[0];
        9: pressed = e[3];
        10: pressed = e[1];
        11: pressed = e[0];
        12, 13, 14, 15: pressed = 1'b0;
        default: pressed = 1'b1;
      endcase
    end
    return !pressed;
  endfunction

  // Monitor: pops one expectation per observation strobe.
  always @(negedge clk) begin
    if (obs_strobe) begin
      logic [7:0] exp_v, act_v;
      int         sel;
      string      nm;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow act=none req=entry");
      end else begin
        exp_v = exp_q.pop_front();
        sel   = sel_q.pop_front();
        nm    = name_q.pop_front();
        case (sel)
          0:       act_v = {7'b0, uo_out[1]};
          1:       act_v = data_out;
          default: act_v = uo_out;
        endcase
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL %s act=0x%02h req=0x%02h t=%0t", nm, act_v, exp_v, $time);
        end
      end
    end
  end

  task automatic observe(input int sel, input logic [7:0] exp_v, input string nm);
    exp_q.push_back(exp_v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
    obs_strobe = 1'b1;
    @(negedge clk);
    #1 obs_strobe = 1'b0;
  endtask

  task automatic chk_wire(input string nm);
    observe(0, {7'b0, model_wire(f_snes, f_btn, f_ext, f_k)}, nm);
  endtask

  task automatic chk_reg(input logic [3:0] a, input string nm);
    logic [7:0] e;
    logic       busy;
    busy = f_active && (f_k < (f_snes ? 16 : 8));
    case (a)
      4'h0:    e = m_btn;
      4'h1:    e = {4'b0, m_ext};
      4'h2:    e = {busy, 6'b0, m_mode};
      4'h3:    e = m_polls;
      4'h4:    e = m_turbo;
      default: e = 8'h00;
    endcase
    address = a;
    observe(1, e, nm);
  endtask

  task automatic model_reset();
    m_btn = 0; m_ext = 0; m_mode = 0; m_polls = 0; m_turbo = 0; m_falls = 0;
    f_snes = 0; f_btn = 0; f_ext = 0; f_k = 0; f_active = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    address = a; data_in = d; data_write = 1'b1;
    @(posedge clk); #1;
    data_write = 1'b0;
    case (a)
      4'h0: m_btn = d;
      4'h1: m_ext = d[3:0];
      4'h2: m_mode = d[0];
      4'h3: m_polls = 8'h00;
`ifdef SNES_DEVICE_TURBO_EN
      4'h4: m_turbo = d;
`endif
      default: ;
    endcase
  endtask

  task automatic capture();
    f_snes = m_mode;
    f_ext  = m_ext;
    f_btn  = m_btn & ~(m_turbo & {8{(m_falls % 2) == 1}});
    f_k    = 0;
    f_active = 1'b0;
  endtask

  task automatic cclk();
    @(posedge clk); #1 ui_in[6] = 1'b1;
    repeat (2) @(posedge clk);
    #1 ui_in[6] = 1'b0;
    if (!ui_in[5]) f_k++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic latch(input int hold_clks);
    @(posedge clk); #1 ui_in[5] = 1'b1;
    capture();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < hold_clks; i++) cclk();
    if (hold_clks > 0) chk_wire("latch_high_wire");
    ui_in[5] = 1'b0;
    m_falls++; m_polls++; f_active = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n, input string nm);
    chk_wire(nm);
    for (int i = 0; i < n; i++) begin
      cclk();
      chk_wire(nm);
    end
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog act=timeout req=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    observe(2, 8'h02, "reset_uo");
    for (int a = 0; a < 5; a++) chk_reg(4'(a), "reset_reg");

    // Turbo register (or its absence) right after reset so phase starts at 0.
    wr(4'h4, 8'hFF);
    chk_reg(4'h4, "turbo_read");
    wr(4'h4, 8'h01); wr(4'h0, 8'h01);
    for (int i = 0; i < 4; i++) begin
      latch(0);
      chk_wire("turbo_first_bit");
    end
    wr(4'h4, 8'h00);

    // SNES frame: A and X pressed.
    wr(4'h2, 8'h01); wr(4'h0, 8'h01); wr(4'h1, 8'h08); wr(4'h3, 8'h00);
    latch(0);
    frame(17, "snes_frame");
    chk_reg(4'h3, "snes_polls");

    // NES frame with busy tracking.
    wr(4'h2, 8'h00); wr(4'h0, 8'h81);
    latch(0);
    chk_wire("nes_frame");
    chk_reg(4'h2, "nes_busy");
    for (int i = 0; i < 9; i++) begin
      cclk();
      chk_wire("nes_frame");
      chk_reg(4'h2, "nes_busy");
    end

    // Latch held high while the console clocks.
    wr(4'h0, 8'h02);
    latch(3);
    chk_wire("after_hold_bit0");
    cclk();
    chk_wire("after_hold_bit1");

    // Re-latch mid-frame, then POLLS clear coincident with latch fall.
    wr(4'h0, 8'h5A);
    latch(0);
    repeat (5) cclk();
    latch(0);
    chk_wire("relatch_bit0");
    @(posedge clk); #1 ui_in[5] = 1'b1;
    capture();
    @(posedge clk); #1;
    @(posedge clk); #1 ui_in[5] = 1'b0; address = 4'h3; data_write = 1'b1;
    @(posedge clk); #1 data_write = 1'b0;
    m_falls++; m_polls = 8'h00; f_active = 1'b1;
    chk_reg(4'h3, "polls_clear_prio");

    // CPU write to BTN in the last load cycle: frame carries the old value.
    wr(4'h0, 8'h55);
    @(posedge clk); #1 ui_in[5] = 1'b1;
    capture();
    @(posedge clk); #1 address = 4'h0; data_in = 8'hAA; data_write = 1'b1;
    @(posedge clk); #1 data_write = 1'b0; ui_in[5] = 1'b0;
    m_btn = 8'hAA; m_falls++; m_polls++; f_active = 1'b1;
    frame(3, "write_vs_load");
    chk_reg(4'h0, "btn_after_write");

    // Mode change mid-frame applies only at the next latch.
    wr(4'h2, 8'h00); wr(4'h0, 8'h0F);
    latch(0);
    wr(4'h2, 8'h01);
    frame(10, "mode_deferred");
    chk_reg(4'h2, "mode_ctrl");

    // Random frames.
    for (int it = 0; it < 12; it++) begin
      int n;
      wr(4'h0, 8'($urandom_range(0, 255)));
      wr(4'h1, 8'($urandom_range(0, 15)));
      wr(4'h2, 8'($urandom_range(0, 1)));
      latch($urandom_range(0, 2));
      n = $urandom_range(0, 18);
      frame(n, "rand_frame");
      chk_reg(4'h2, "rand_ctrl");
      chk_reg(4'h3, "rand_polls");
      chk_reg(4'($urandom_range(5, 15)), "rand_unmapped");
    end

    // POLLS wraps 255 -> 0.
    wr(4'h3, 8'h00);
    repeat (256) latch(0);
    chk_reg(4'h3, "polls_wrap");

    // Reset mid-frame.
    wr(4'h0, 8'hFF); wr(4'h2, 8'h01);
    latch(0);
    repeat (2) cclk();
    @(posedge clk); #3 rst_n = 1'b0;
    model_reset();
    observe(2, 8'h02, "midframe_reset_uo");
    for (int a = 0; a < 5; a++) chk_reg(4'(a), "midframe_reset_reg");
    @(posedge clk); #1 rst_n = 1'b1;
    cclk();
    chk_reg(4'h2, "post_reset_ctrl");

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain act=%0d req=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
